hash_sram_arbiter: RTL
======================

Name: hash_sram_arbiter

Overview:
- Shares one single-port hash-table SRAM (active-low CSB/WEB/OEB) between two requesters:
  - the hash-generation path (gen), which writes hashed rows;
  - the query/lookup path (qry), which reads and writes rows during error-correction lookups.
- Sits between both controllers and the SRAM macro.
- Serialises accesses, applies a priority policy with anti-starvation, and returns read data with a valid pulse.

Parameters:
- ADDR_W, 8, SRAM address width.
- DATA_W, 32, SRAM data width.
- RD_LAT, 1, SRAM read latency in cycles (>=1) from access cycle to valid sram_dout.
- GEN_PRIO, 1, 1 = gen has fixed priority; 0 = round-robin.
- MAX_WAIT, 4, in fixed-priority mode, consecutive qry losses before qry is forced a grant (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- gen_req  in  1  gen access request; held with cmd until gen_gnt.
- gen_we  in  1  1 = write, 0 = read.
- gen_addr  in  ADDR_W  gen address.
- gen_wdata  in  DATA_W  gen write data.
- gen_gnt  out  1  one-cycle pulse: gen command issued to SRAM this cycle.
- gen_rvalid  out  1  one-cycle pulse: rdata holds gen read result.
- qry_req, qry_we, qry_addr, qry_wdata  in  1/1/ADDR_W/DATA_W  same as gen_*.
- qry_gnt  out  1  same as gen_gnt.
- qry_rvalid  out  1  same as gen_rvalid.
- rdata  out  DATA_W  registered read data, valid with *_rvalid, held until next read.
- sram_csb  out  1  chip select, active low.
- sram_web  out  1  write enable, active low.
- sram_oeb  out  1  output enable, active low.
- sram_addr  out  ADDR_W  SRAM address.
- sram_din  out  DATA_W  SRAM write data.
- sram_dout  in  DATA_W  SRAM read data.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous, active-low, sampled on the rising clk edge.
- Reset values:
  - state = IDLE.
  - All gnt/rvalid outputs = 0; busy = 0.
  - sram_csb = sram_web = sram_oeb = 1; sram_addr = 0; sram_din = 0; rdata = 0.
  - last_winner = QRY, so gen wins the first round-robin tie; qry_wait_cnt = 0.
- Outputs are registered.
- States: IDLE, ACCESS, RD_WAIT, RESP.
- IDLE:
  - Sample requests at the edge. If any req is high, pick the winner.
  - Capture the winner's we/addr/wdata into the command register and go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both, GEN_PRIO=1: gen wins unless qry_wait_cnt >= MAX_WAIT, in which case qry wins.
  - Both, GEN_PRIO=0: the requester != last_winner wins.
  - qry_wait_cnt increments, saturating at MAX_WAIT, each time qry loses with both requesting. It clears on a qry grant.
  - last_winner updates on every grant.
- ACCESS (exactly 1 cycle):
  - Winner's gnt = 1; sram_csb = 0; sram_addr/sram_din driven from the command register.
  - Write: sram_web = 0 this cycle, then go to IDLE.
  - Read: sram_web = 1, then go to RD_WAIT.
- RD_WAIT (RD_LAT cycles):
  - sram_csb = 0; sram_oeb = 0; sram_addr is held.
  - rdata captures sram_dout at the edge ending the last RD_WAIT cycle, then go to RESP.
- RESP (1 cycle):
  - Owner's rvalid = 1; all SRAM controls are inactive (sram_oeb = 1).
  - Then go to IDLE.
- Latency from req first high in IDLE cycle N:
  - gnt in cycle N+1.
  - Write lands at the end of N+1.
  - Read: rvalid in cycle N+2+RD_LAT.
  - Next arbitration is at IDLE, one cycle after ACCESS (write) or after RESP (read).
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt.
  - Deassert req in the cycle after gnt, or present the next command.
  - A req raised while busy waits; it is never dropped.
- Mutual exclusion: at most one gnt and at most one rvalid high per cycle. gnt and rvalid of different requesters are never high together.
- Outside ACCESS/RD_WAIT: sram_csb = sram_web = sram_oeb = 1. sram_addr and sram_din hold their last values.
- Reset mid-operation: the state returns to IDLE at the next edge. An in-flight read is discarded: no rvalid, and rdata resets to 0. A write already in ACCESS is not retried.
- Counter widths: qry_wait_cnt is $clog2(MAX_WAIT+1) bits and never wraps.

Test Plan:
- Single gen write:
  - Stimulus: gen_req = 1, we = 1, addr = 0x12, wdata = 0xDEADBEEF at cycle N.
  - Response: gen_gnt, sram_csb = 0, sram_web = 0, sram_addr = 0x12, sram_din = 0xDEADBEEF all in N+1. busy drops at N+2.
- Single qry read, RD_LAT = 1:
  - Stimulus: qry read addr = 0x12; model returns 0xDEADBEEF one cycle after the access.
  - Response: qry_gnt at N+1; sram_oeb = 0 at N+2; qry_rvalid = 1 with rdata = 0xDEADBEEF at N+3; gen_rvalid stays 0.
- Contention, GEN_PRIO = 1, MAX_WAIT = 4:
  - Stimulus: gen and qry request continuously (writes).
  - Response: grant order is gen ×4, qry, gen ×4, qry. qry_wait_cnt saturates at 4, then clears.
- Contention, GEN_PRIO = 0:
  - Stimulus: both request continuously (writes) from reset.
  - Response: grants alternate gen, qry, gen, qry.
- Reset mid-read:
  - Stimulus: assert reset = 0 during RD_WAIT of a gen read.
  - Response: next cycle state IDLE, all SRAM controls = 1, rdata = 0. No gen_rvalid ever appears for that read.
- RD_LAT = 3:
  - Stimulus: gen read.
  - Response: sram_oeb = 0 for 3 cycles; gen_rvalid exactly at N+5.

Source files
------------

// File: rtl/hash_sram_arbiter.sv
// Arbiter sharing one single-port hash-table SRAM (active-low controls) between the
// hash-generation path (gen) and the query/lookup path (qry); read data returns with a valid pulse.
module hash_sram_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int RD_LAT   = 1,
   parameter int GEN_PRIO = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gen_req,
   input  logic              gen_we,
   input  logic [ADDR_W-1:0] gen_addr,
   input  logic [DATA_W-1:0] gen_wdata,
   output logic              gen_gnt,
   output logic              gen_rvalid,
   input  logic              qry_req,
   input  logic              qry_we,
   input  logic [ADDR_W-1:0] qry_addr,
   input  logic [DATA_W-1:0] qry_wdata,
   output logic              qry_gnt,
   output logic              qry_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_oeb,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout,
   output logic              busy
);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
   localparam logic OWN_GEN = 1'b0;
   localparam logic OWN_QRY = 1'b1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RD_WAIT = 2'd2, RESP = 2'd3} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                cmd_we_q, cmd_we_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                gen_gnt_q, gen_gnt_d, qry_gnt_q, qry_gnt_d;
   logic                gen_rvalid_q, gen_rvalid_d, qry_rvalid_q, qry_rvalid_d;
   logic                csb_q, csb_d, web_q, web_d, oeb_q, oeb_d, busy_q, busy_d;
   logic                win_qry;

   // owner_q doubles as last_winner; addr_q/din_q are both the command register and the SRAM bus
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= OWN_QRY;
         cmd_we_q     <= 1'b0;
         wait_cnt_q   <= '0;
         lat_cnt_q    <= '0;
         addr_q       <= '0;
         din_q        <= '0;
         rdata_q      <= '0;
         gen_gnt_q    <= 1'b0;
         qry_gnt_q    <= 1'b0;
         gen_rvalid_q <= 1'b0;
         qry_rvalid_q <= 1'b0;
         csb_q        <= 1'b1;
         web_q        <= 1'b1;
         oeb_q        <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         cmd_we_q     <= cmd_we_d;
         wait_cnt_q   <= wait_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         rdata_q      <= rdata_d;
         gen_gnt_q    <= gen_gnt_d;
         qry_gnt_q    <= qry_gnt_d;
         gen_rvalid_q <= gen_rvalid_d;
         qry_rvalid_q <= qry_rvalid_d;
         csb_q        <= csb_d;
         web_q        <= web_d;
         oeb_q        <= oeb_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cmd_we_d   = cmd_we_q;
      wait_cnt_d = wait_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      addr_d     = addr_q;
      din_d      = din_q;
      win_qry    = 1'b0;
      case (state_q)
         IDLE: begin
            if (gen_req || qry_req) begin
               if (gen_req && qry_req) begin
                  if (GEN_PRIO != 0) begin
                     win_qry = (wait_cnt_q >= WAIT_MAX);
                  end else begin
                     win_qry = (owner_q == OWN_GEN);
                  end
                  // qry loss count saturates so a starved qry keeps its forced grant
                  if (!win_qry && (wait_cnt_q < WAIT_MAX)) begin
                     wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                  end else begin
                     wait_cnt_d = wait_cnt_q;
                  end
               end else begin
                  win_qry = qry_req;
               end
               if (win_qry) begin
                  wait_cnt_d = '0;
                  owner_d    = OWN_QRY;
                  cmd_we_d   = qry_we;
                  addr_d     = qry_addr;
                  din_d      = qry_wdata;
               end else begin
                  owner_d    = OWN_GEN;
                  cmd_we_d   = gen_we;
                  addr_d     = gen_addr;
                  din_d      = gen_wdata;
               end
               state_d = ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            lat_cnt_d = '0;
            state_d   = cmd_we_q ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
               state_d = RESP;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs are decoded from the next state so every pin leaves a flop
   always_comb begin
      gen_gnt_d    = (state_d == ACCESS) && (owner_d == OWN_GEN);
      qry_gnt_d    = (state_d == ACCESS) && (owner_d == OWN_QRY);
      gen_rvalid_d = (state_d == RESP) && (owner_d == OWN_GEN);
      qry_rvalid_d = (state_d == RESP) && (owner_d == OWN_QRY);
      csb_d        = !((state_d == ACCESS) || (state_d == RD_WAIT));
      web_d        = !((state_d == ACCESS) && cmd_we_d);
      oeb_d        = (state_d != RD_WAIT);
      busy_d       = (state_d != IDLE);
      if ((state_q == RD_WAIT) && (lat_cnt_q == LAT_LAST)) begin
         rdata_d = sram_dout;
      end else begin
         rdata_d = rdata_q;
      end
   end

   assign gen_gnt    = gen_gnt_q;
   assign qry_gnt    = qry_gnt_q;
   assign gen_rvalid = gen_rvalid_q;
   assign qry_rvalid = qry_rvalid_q;
   assign rdata      = rdata_q;
   assign sram_csb   = csb_q;
   assign sram_web   = web_q;
   assign sram_oeb   = oeb_q;
   assign sram_addr  = addr_q;
   assign sram_din   = din_q;
   assign busy       = busy_q;
endmodule
